ifid_decode_stage: RTL
======================

// Module: ifid_decode_stage
// PURPOSE
//  IF/ID stage of the MIPS datapath, directly upstream of signext.
//  - Accepts fetched instruction words with their PC over a valid/ready handshake.
//  - Buffers them in a 2-entry skid FIFO.
//  - Presents the head entry with its fields split out: opcode, registers, imm16, jump target.
//  - imm16 drives signext.a. zext tells the extension mux to bypass signext for logical immediates.
// PARAMETERS
//  DEPTH   2   FIFO entries. Fixed at 2; any other value is a compile-time $error.
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, synchronous, active-low
//  flush      in   1   discard all buffered entries (branch/jump taken)
//  in_valid   in   1   fetch word valid
//  in_ready   out  1   stage can accept; = (count != 2)
//  in_instr   in   32  instruction word
//  in_pc      in   32  PC of in_instr
//  out_valid  out  1   head entry valid; = (count != 0)
//  out_ready  in   1   ID/EX consumes head
//  out_instr  out  32  head instruction
//  out_pc     out  32  head PC
//  opcode     out  6   instr[31:26]
//  rs         out  5   instr[25:21]
//  rt         out  5   instr[20:16]
//  rd         out  5   instr[15:11]
//  shamt      out  5   instr[10:6]
//  funct      out  6   instr[5:0]
//  imm16      out  16  instr[15:0]; goes to signext
//  jaddr      out  26  instr[25:0]
//  zext       out  1   1 for andi/ori/xori (opcode 0x0C/0x0D/0x0E); 0 otherwise
//  itype      out  2   00 R (opcode 0x00); 10 J (opcode 0x02/0x03); 01 all others
// BEHAVIOUR
//  State and reset
//  - State is count[1:0] (0..2) plus head/tail pointers (1 bit each) over 2x64-bit storage.
//  - rst=0 at a clk edge: count=0, pointers=0. Storage contents are don't-care.
//  - Reset wins over every other input. It aborts any in-flight entries, including mid-drain.
//  Handshake
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the rising edge.
//  - Latency: a word pushed at edge N appears on out_* after edge N when the FIFO was empty.
//  - Ordering is strict FIFO. No entry is dropped or duplicated except by flush/reset.
//  - push & pop with count=1: count stays 1, head advances, new word becomes head.
//  - push & pop with count=0: impossible, because out_valid=0.
//  - count=2: in_ready=0. A pop on that edge does not allow a same-edge push; in_ready rises next cycle.
//  - in_valid may drop without a transfer. out_ready may toggle freely.
//  - While out_valid=1 and out_ready=0, out_* and the decoded fields are held stable.
//  Flush
//  - At the edge: count=0 and pointers=0. A push on the same edge is discarded.
//  - A pop on the same edge is still counted as taken by downstream.
//  Decode
//  - All decode fields are combinational slices of the head instruction.
//  - When out_valid=0, out_instr, out_pc and all fields are forced to 0, which gives zext=0 and itype=00.
// CONFIGURATION
//  IFID_STATS_EN
//  - Defined: adds output port stall_cnt[15:0].
//    - Increments once per cycle with out_valid & ~out_ready.
//    - Saturates at 16'hFFFF.
//    - Cleared only by rst. flush does not clear it.
//  - Undefined: the port and the counter are absent. All other behaviour is identical.
// TESTING
//  1. Reset held 2 cycles with in_valid=1 -> out_valid=0 and count=0 throughout; in_ready=1 after release.
//  2. Push 0x2008FFFF (addi), out_ready=1 -> next cycle:
//     opcode=0x08, rs=0, rt=8, imm16=0xFFFF, zext=0, itype=01; signext output 0xFFFFFFFF.
//  3. Push 0x3508FFFF (ori) -> zext=1, imm16=0xFFFF.
//     Push 0x01095020 (add) -> rs=8, rt=9, rd=10, funct=0x20, itype=00.
//  4. Push 0x08000010 (j) -> opcode=0x02, jaddr=0x0000010, itype=10.
//  5. out_ready=0; offer 3 words A,B,C back-to-back -> A,B accepted, in_ready=0, C held.
//     Raise out_ready -> A, B, C delivered in order, each for exactly 1 cycle.
//  6. count=2 then flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, offered word not stored.
//     With IFID_STATS_EN: stall_cnt equals the number of stalled cycles in test 5 and is unchanged by the flush.

Source files
------------

// File: rtl/ifid_decode_stage.sv
// IF/ID stage: 2-entry skid FIFO for fetched words plus head-instruction field decode.
// Optional IFID_STATS_EN adds a saturating downstream-stall counter (stall_cnt).
module ifid_decode_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        zext,
  output logic [1:0]  itype
`ifdef IFID_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  if (DEPTH != 2) begin : g_depth_chk
    $error("ifid_decode_stage: DEPTH must be 2");
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t     mem [2];
  entry_t     head;
  logic [1:0] count;
  logic       hd;
  logic       tl;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count <= 2'd0;
      hd    <= 1'b0;
      tl    <= 1'b0;
    end else begin
      if (push) tl <= ~tl;
      if (pop)  hd <= ~hd;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset; flushed/reset slots are unreachable until rewritten
  always_ff @(posedge clk) begin
    if (rst && !flush && push)
      mem[tl] <= '{pc: in_pc, instr: in_instr};
  end

  assign head      = out_valid ? mem[hd] : '0;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  assign opcode = out_instr[31:26];
  assign rs     = out_instr[25:21];
  assign rt     = out_instr[20:16];
  assign rd     = out_instr[15:11];
  assign shamt  = out_instr[10:6];
  assign funct  = out_instr[5:0];
  assign imm16  = out_instr[15:0];
  assign jaddr  = out_instr[25:0];

  // andi/ori/xori zero-extend, so the extension mux bypasses signext
  assign zext = (opcode == 6'h0C) | (opcode == 6'h0D) |
                (opcode == 6'h0E);

  always_comb begin
    itype = 2'b01;
    unique case (1'b1)
      (opcode == 6'h00):                     itype = 2'b00;
      (opcode == 6'h02) | (opcode == 6'h03): itype = 2'b10;
      default:                               itype = 2'b01;
    endcase
  end

`ifdef IFID_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= 16'd0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
